div_sqrt_preproc_mvp: RTL and testbench
=======================================

Name: div_sqrt_preproc_mvp

Overview:
- Operand preprocessing stage directly upstream of the div/sqrt control FSM.
- Accepts raw IEEE operands and unpacks fields per format.
- Classifies special cases and normalises subnormal mantissas iteratively.
- Presents aligned 53-bit mantissas and signed 12-bit exponents to the control stage under a start/ready handshake.

Parameters:
- C_MANT_FP64, 52, FP64 mantissa width; mantissa outputs are C_MANT_FP64+1 bits.
- C_EXP_FP64, 11, FP64 exponent width; exponent outputs are C_EXP_FP64+1 bits, signed.
- SHIFT_STEP, 8, maximum left-shift applied per cycle during subnormal normalisation (1..53).

Ports:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset, asynchronous, active-low
- Div_start_SI  in  1  request divide; sampled only when Ready_SO=1
- Sqrt_start_SI  in  1  request sqrt of operand A; sampled only when Ready_SO=1
- Kill_SI  in  1  abort the current operation
- Format_sel_SI  in  2  00 FP32, 01 FP64, 10 FP16, 11 FP16ALT
- Operand_a_DI  in  64  numerator / radicand, right-aligned
- Operand_b_DI  in  64  denominator, right-aligned
- Ready_SI  in  1  downstream control stage accepts
- Ready_SO  out  1  stage idle, may accept a request
- Start_SO  out  1  valid result toward the control stage
- Div_op_SO  out  1  1 = div, 0 = sqrt; registered
- Format_sel_SO  out  2  registered format
- Numerator_DO  out  53  A mantissa, hidden bit at bit 52
- Exp_num_DO  out  12  A exponent, signed, biased
- Denominator_DO  out  53  B mantissa
- Exp_den_DO  out  12  B exponent
- Sign_z_SO  out  1  result sign
- Special_case_SBO  out  1  active-low: result is special, bypass iteration
- Special_case_dly_SBO  out  1  Special_case_SBO delayed one cycle
- Special_kind_DO  out  3  0 none, 1 invalid qNaN, 2 propagate NaN, 3 inf, 4 zero
- Div_by_zero_SO  out  1  finite nonzero / zero

Behaviour:
- Reset values:
  - Ready_SO=1.
  - Special_case_SBO=1 and Special_case_dly_SBO=1.
  - All other outputs 0.
- Field widths (exp, mant):
  - FP32: 8, 23.
  - FP64: 11, 52.
  - FP16: 5, 10.
  - FP16ALT: 8, 7.
- Unpacking:
  - Mantissa is left-aligned so the hidden bit lands at bit 52; unused low bits are 0.
  - Hidden bit is 1 if exp!=0, else 0.
  - Exponent out = biased exp for normals; 1 - shift_total for subnormals (may go negative).
- Request decode: request = (Div_start_SI|Sqrt_start_SI) & Ready_SO. If both start inputs are high, div wins.
- Sign: Sign_z_SO = signA^signB for div; signA for sqrt.
- Special cases, div:
  - Either NaN: kind 2; kind 1 if that NaN is signalling.
  - 0/0 or inf/inf: kind 1.
  - x/0: kind 3 with Div_by_zero_SO=1.
  - inf/x: kind 3.
  - 0/x or x/inf: kind 4.
- Special cases, sqrt:
  - NaN: kind 2.
  - Negative nonzero (including -inf): kind 1.
  - ±0: kind 4, sign kept.
  - +inf: kind 3.
- Special-case precedence: NaN > invalid > div-by-zero > inf > zero.
- FSM states IDLE, NORM, HOLD:
  - IDLE: Ready_SO=1. On request, capture and classify all registers.
    - Special case -> HOLD, Special_case_SBO=0; NORM is skipped.
    - Any operand subnormal and nonzero (B only for div) -> NORM.
    - Otherwise -> HOLD.
  - NORM: Ready_SO=0. Each cycle, every mantissa with bit52=0 shifts left by min(SHIFT_STEP, its leading-zero count) and its exponent decrements by the same amount. Exit to HOLD in the cycle both bit52 are 1.
  - HOLD: Start_SO=1; all data outputs stable. Ready_SI=1 -> IDLE next cycle, Start_SO=0.
- Latency: normal operands give Start_SO one cycle after the request. Subnormals add ceil(lz/SHIFT_STEP) cycles, max 7 for FP64 at the default step.
- Kill_SI in any state -> IDLE next cycle; Start_SO=0 and Special_case_SBO=1. Kill wins over a simultaneous request or Ready_SI.
- Special_case_dly_SBO is a plain one-cycle register of Special_case_SBO, including across Kill.
- Asynchronous reset mid-operation returns to IDLE with reset values immediately.

Optional Feature:
- Macro: PREPROC_FTZ_EN.
- Defined: subnormal inputs are treated as ±0 before classification. NORM is never entered, and special handling follows the zero rules.
- Undefined: full subnormal normalisation as specified above.

Test Plan:
- FP32 div 0x40C00000 / 0x40000000 -> Start_SO one cycle after request; Numerator_DO=0x18000000000000; Exp_num_DO=129; Denominator_DO=0x10000000000000; Exp_den_DO=128; Special_case_SBO=1; Sign_z_SO=0.
- FP64 sqrt 0x0000000000000001, SHIFT_STEP=8 -> 7 NORM cycles, Start_SO on cycle 8; Numerator_DO=0x10000000000000; Exp_num_DO=-51 (0xFCD).
- FP32 div 0x3F800000 / 0x00000000 -> Start_SO next cycle; Special_case_SBO=0; Special_kind_DO=3; Div_by_zero_SO=1; Special_case_dly_SBO=0 one cycle later.
- FP16 sqrt 0xC400 -> Special_kind_DO=1; FP16 div 0x7E00 / 0x3C00 -> Special_kind_DO=2.
- FP64 subnormal div with Kill_SI asserted in 3rd NORM cycle -> IDLE, Ready_SO=1 next cycle; Start_SO never asserted; new request accepted immediately after.
- Ready_SI held low 3 cycles in HOLD -> Start_SO and all data outputs unchanged for those cycles; Ready_SO=1 one cycle after Ready_SI rises.

Source files
------------

// File: rtl/div_sqrt_preproc_mvp.sv
// div_sqrt_preproc_mvp: operand preprocessing ahead of the div/sqrt control FSM.
// Unpacks FP32/FP64/FP16/FP16ALT operands into 53-bit mantissas (hidden bit at
// bit 52) and signed 12-bit exponents. It also classifies special cases and
// normalises subnormal mantissas a few bits per cycle.
// Optional build macro PREPROC_FTZ_EN: subnormal inputs are flushed to signed
// zero before classification, so the NORM state is never entered.
//
// state | meaning
// IDLE  | ready for a request; operands are captured and classified on request
// NORM  | left-normalising subnormal mantissa(s), up to SHIFT_STEP bits per cycle
// HOLD  | result presented with Start_SO=1 until Ready_SI accepts it
module div_sqrt_preproc_mvp #(
  parameter int C_MANT_FP64 = 52,
  parameter int C_EXP_FP64  = 11,
  parameter int SHIFT_STEP  = 8
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  input  logic                   Div_start_SI,
  input  logic                   Sqrt_start_SI,
  input  logic                   Kill_SI,
  input  logic [1:0]             Format_sel_SI,
  input  logic [63:0]            Operand_a_DI,
  input  logic [63:0]            Operand_b_DI,
  input  logic                   Ready_SI,
  output logic                   Ready_SO,
  output logic                   Start_SO,
  output logic                   Div_op_SO,
  output logic [1:0]             Format_sel_SO,
  output logic [C_MANT_FP64:0]   Numerator_DO,
  output logic [C_EXP_FP64:0]    Exp_num_DO,
  output logic [C_MANT_FP64:0]   Denominator_DO,
  output logic [C_EXP_FP64:0]    Exp_den_DO,
  output logic                   Sign_z_SO,
  output logic                   Special_case_SBO,
  output logic                   Special_case_dly_SBO,
  output logic [2:0]             Special_kind_DO,
  output logic                   Div_by_zero_SO
);

  localparam int MW  = C_MANT_FP64 + 1;
  localparam int EW  = C_EXP_FP64 + 1;
  localparam int LZW = $clog2(MW + 1);
  localparam logic [LZW-1:0] STEP_W = LZW'(SHIFT_STEP);

  localparam logic [2:0] K_NONE = 3'd0;
  localparam logic [2:0] K_INV  = 3'd1;
  localparam logic [2:0] K_NAN  = 3'd2;
  localparam logic [2:0] K_INF  = 3'd3;
  localparam logic [2:0] K_ZERO = 3'd4;

  typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
    logic          is_nan;
    logic          is_snan;
    logic          is_inf;
    logic          is_zero;
    logic          is_sub;
  } opnd_t;

  // Field extraction per format; mantissa left-aligned below the hidden bit.
  function automatic opnd_t unpack(input logic [63:0] op, input logic [1:0] fmt);
    opnd_t                  r;
    logic [C_EXP_FP64-1:0]  e;
    logic [C_MANT_FP64-1:0] m;
    logic                   e_max;
    case (fmt)
      2'b00: begin
        r.sign = op[31];
        e      = {{(C_EXP_FP64-8){1'b0}}, op[30:23]};
        m      = {op[22:0], {(C_MANT_FP64-23){1'b0}}};
        e_max  = &op[30:23];
      end
      2'b01: begin
        r.sign = op[63];
        e      = op[C_MANT_FP64 +: C_EXP_FP64];
        m      = op[C_MANT_FP64-1:0];
        e_max  = &op[C_MANT_FP64 +: C_EXP_FP64];
      end
      2'b10: begin
        r.sign = op[15];
        e      = {{(C_EXP_FP64-5){1'b0}}, op[14:10]};
        m      = {op[9:0], {(C_MANT_FP64-10){1'b0}}};
        e_max  = &op[14:10];
      end
      default: begin
        r.sign = op[15];
        e      = {{(C_EXP_FP64-8){1'b0}}, op[14:7]};
        m      = {op[6:0], {(C_MANT_FP64-7){1'b0}}};
        e_max  = &op[14:7];
      end
    endcase
`ifdef PREPROC_FTZ_EN
    if (e == '0) m = '0;
`endif
    r.is_nan  = e_max & (|m);
    r.is_snan = e_max & (|m) & ~m[C_MANT_FP64-1];
    r.is_inf  = e_max & ~(|m);
    r.is_zero = (e == '0) & ~(|m);
    r.is_sub  = (e == '0) & (|m);
    r.mant    = {(e != '0), m};
    if (r.is_sub) r.exp = EW'(1);
    else          r.exp = {1'b0, e};
    return r;
  endfunction

  // Leading-zero count of a mantissa; the highest set bit wins.
  function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (v[i]) n = LZW'(MW - 1 - i);
    end
    return n;
  endfunction

  state_t         state_q, state_n;
  opnd_t          ua, ub;
  logic           req, need_norm_c, dbz_c;
  logic [2:0]     kind_c;
  logic [LZW-1:0] lz_a, lz_b, sh_a, sh_b;
  logic [MW-1:0]  num_sh, den_sh;
  logic [EW-1:0]  exp_num_sh, exp_den_sh;
  logic           norm_done;

  logic           div_op_q, sign_z_q, spec_b_q, spec_dly_q, dbz_q;
  logic [1:0]     fmt_q;
  logic [MW-1:0]  num_q, den_q;
  logic [EW-1:0]  exp_num_q, exp_den_q;
  logic [2:0]     kind_q;

  assign req = (Div_start_SI | Sqrt_start_SI) & Ready_SO;

  // Unpack and classify the raw operands; div wins if both starts are high.
  always_comb begin
    ua          = unpack(Operand_a_DI, Format_sel_SI);
    ub          = unpack(Operand_b_DI, Format_sel_SI);
    kind_c      = K_NONE;
    dbz_c       = 1'b0;
    need_norm_c = 1'b0;
    if (Div_start_SI) begin
      need_norm_c = ua.is_sub | ub.is_sub;
      if (ua.is_nan | ub.is_nan)
        kind_c = (ua.is_snan | ub.is_snan) ? K_INV : K_NAN;
      else if ((ua.is_zero & ub.is_zero) | (ua.is_inf & ub.is_inf))
        kind_c = K_INV;
      else if (ub.is_zero) begin
        kind_c = K_INF;
        dbz_c  = ~ua.is_inf;
      end
      else if (ua.is_inf)
        kind_c = K_INF;
      else if (ua.is_zero | ub.is_inf)
        kind_c = K_ZERO;
    end else begin
      need_norm_c = ua.is_sub;
      if (ua.is_nan)                    kind_c = K_NAN;
      else if (ua.sign & ~ua.is_zero)   kind_c = K_INV;
      else if (ua.is_zero)              kind_c = K_ZERO;
      else if (ua.is_inf)               kind_c = K_INF;
    end
  end

  // One normalisation step; the denominator only takes part for divide.
  always_comb begin
    lz_a       = lzc(num_q);
    lz_b       = lzc(den_q);
    sh_a       = '0;
    sh_b       = '0;
    if (!num_q[MW-1])
      sh_a = (lz_a > STEP_W) ? STEP_W : lz_a;
    if (div_op_q && !den_q[MW-1])
      sh_b = (lz_b > STEP_W) ? STEP_W : lz_b;
    num_sh     = num_q << sh_a;
    den_sh     = den_q << sh_b;
    exp_num_sh = exp_num_q - EW'(sh_a);
    exp_den_sh = exp_den_q - EW'(sh_b);
    norm_done  = num_sh[MW-1] & (den_sh[MW-1] | ~div_op_q);
  end

  // State register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) state_q <= IDLE;
    else          state_q <= state_n;
  end

  // Next-state and handshake outputs; kill overrides everything.
  always_comb begin
    state_n  = state_q;
    Ready_SO = 1'b0;
    Start_SO = 1'b0;
    case (state_q)
      IDLE: begin
        Ready_SO = 1'b1;
        if (Div_start_SI | Sqrt_start_SI) begin
          if (kind_c != K_NONE) state_n = HOLD;
          else if (need_norm_c) state_n = NORM;
          else                  state_n = HOLD;
        end
      end
      NORM: begin
        if (norm_done) state_n = HOLD;
      end
      HOLD: begin
        Start_SO = 1'b1;
        if (Ready_SI) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (Kill_SI) state_n = IDLE;
  end

  // Operand capture on request, in-place normalisation while in NORM.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      div_op_q   <= 1'b0;
      fmt_q      <= 2'b00;
      num_q      <= '0;
      exp_num_q  <= '0;
      den_q      <= '0;
      exp_den_q  <= '0;
      sign_z_q   <= 1'b0;
      spec_b_q   <= 1'b1;
      spec_dly_q <= 1'b1;
      kind_q     <= K_NONE;
      dbz_q      <= 1'b0;
    end else begin
      spec_dly_q <= spec_b_q;
      if (Kill_SI) begin
        spec_b_q <= 1'b1;
      end else if (req) begin
        div_op_q  <= Div_start_SI;
        fmt_q     <= Format_sel_SI;
        num_q     <= ua.mant;
        exp_num_q <= ua.exp;
        den_q     <= ub.mant;
        exp_den_q <= ub.exp;
        sign_z_q  <= Div_start_SI ? (ua.sign ^ ub.sign) : ua.sign;
        spec_b_q  <= (kind_c == K_NONE);
        kind_q    <= kind_c;
        dbz_q     <= dbz_c;
      end else if (state_q == NORM) begin
        num_q     <= num_sh;
        den_q     <= den_sh;
        exp_num_q <= exp_num_sh;
        exp_den_q <= exp_den_sh;
      end
    end
  end

  assign Div_op_SO            = div_op_q;
  assign Format_sel_SO        = fmt_q;
  assign Numerator_DO         = num_q;
  assign Exp_num_DO           = exp_num_q;
  assign Denominator_DO       = den_q;
  assign Exp_den_DO           = exp_den_q;
  assign Sign_z_SO            = sign_z_q;
  assign Special_case_SBO     = spec_b_q;
  assign Special_case_dly_SBO = spec_dly_q;
  assign Special_kind_DO      = kind_q;
  assign Div_by_zero_SO       = dbz_q;

endmodule

// File: tb/tb_div_sqrt_preproc_mvp.sv
// Bench for div_sqrt_preproc_mvp: directed and random operations, expected
// results queued by the driver and compared by an independent monitor.
module tb_div_sqrt_preproc_mvp;

  localparam int STEP = 8;

  logic        Clk_CI = 1'b0;
  logic        Rst_RBI = 1'b0;
  logic        Div_start_SI = 1'b0, Sqrt_start_SI = 1'b0, Kill_SI = 1'b0;
  logic [1:0]  Format_sel_SI = 2'b00;
  logic [63:0] Operand_a_DI = '0, Operand_b_DI = '0;
  logic        Ready_SI = 1'b1;
  logic        Ready_SO, Start_SO, Div_op_SO, Sign_z_SO;
  logic        Special_case_SBO, Special_case_dly_SBO, Div_by_zero_SO;
  logic [1:0]  Format_sel_SO;
  logic [52:0] Numerator_DO, Denominator_DO;
  logic [11:0] Exp_num_DO, Exp_den_DO;
  logic [2:0]  Special_kind_DO;

  div_sqrt_preproc_mvp #(.C_MANT_FP64(52), .C_EXP_FP64(11), .SHIFT_STEP(STEP)) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
    .Div_start_SI(Div_start_SI), .Sqrt_start_SI(Sqrt_start_SI), .Kill_SI(Kill_SI),
    .Format_sel_SI(Format_sel_SI), .Operand_a_DI(Operand_a_DI), .Operand_b_DI(Operand_b_DI),
    .Ready_SI(Ready_SI), .Ready_SO(Ready_SO), .Start_SO(Start_SO), .Div_op_SO(Div_op_SO),
    .Format_sel_SO(Format_sel_SO), .Numerator_DO(Numerator_DO), .Exp_num_DO(Exp_num_DO),
    .Denominator_DO(Denominator_DO), .Exp_den_DO(Exp_den_DO), .Sign_z_SO(Sign_z_SO),
    .Special_case_SBO(Special_case_SBO), .Special_case_dly_SBO(Special_case_dly_SBO),
    .Special_kind_DO(Special_kind_DO), .Div_by_zero_SO(Div_by_zero_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct {
    logic        dv;
    logic [1:0]  fmt;
    logic [52:0] num, den;
    logic [11:0] en, ed;
    logic        sign, sb, dbz;
    logic [2:0]  kind;
    int          lat;
    longint      req_cyc;
  } exp_t;

  typedef struct {
    logic        s, nan, snan, inf, zero, sub;
    logic [52:0] raw, norm;
    int          exp, shift;
  } opi_t;

  exp_t   sbq[$];
  int     n_tests = 0, n_fail = 0;
  longint cyc = 0;

  always @(posedge Clk_CI) cyc = cyc + 1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clk_CI);
    #1;
  endtask

  function automatic void widths(input logic [1:0] f, output int ew, output int mw);
    case (f)
      2'b00: begin ew = 8;  mw = 23; end
      2'b01: begin ew = 11; mw = 52; end
      2'b10: begin ew = 5;  mw = 10; end
      default: begin ew = 8; mw = 7; end
    endcase
  endfunction

  // Reference decode: numeric field extraction and total normalising shift.
  function automatic opi_t ref_op(input logic [63:0] op, input logic [1:0] f);
    opi_t r;
    int ew, mw;
    logic [63:0] e, m, emax;
    widths(f, ew, mw);
    m    = op & ((64'd1 << mw) - 1);
    e    = (op >> mw) & ((64'd1 << ew) - 1);
    emax = (64'd1 << ew) - 1;
    r.s  = op[ew + mw];
`ifdef PREPROC_FTZ_EN
    if (e == 0) m = 0;
`endif
    r.nan  = (e == emax) && (m != 0);
    r.snan = r.nan && (m[mw-1] == 1'b0);
    r.inf  = (e == emax) && (m == 0);
    r.zero = (e == 0) && (m == 0);
    r.sub  = (e == 0) && (m != 0);
    r.raw  = 53'(((e != 0) ? (64'd1 << 52) : 64'd0) | (m << (52 - mw)));
    r.exp  = (e != 0) ? int'(e) : (r.sub ? 1 : 0);
    r.norm = r.raw;
    r.shift = 0;
    if (r.sub) while (r.norm[52] == 1'b0) begin
      r.norm = r.norm << 1;
      r.shift++;
    end
    return r;
  endfunction

  function automatic exp_t ref_model(input logic dv, input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    exp_t x;
    opi_t A, B;
    logic norm;
    int sh;
    A = ref_op(a, f);
    B = ref_op(b, f);
    x.dv = dv; x.fmt = f; x.dbz = 1'b0; x.kind = 3'd0;
    x.sign = dv ? (A.s ^ B.s) : A.s;
    if (dv) begin
      if (A.nan || B.nan)                            x.kind = (A.snan || B.snan) ? 3'd1 : 3'd2;
      else if ((A.zero && B.zero) || (A.inf && B.inf)) x.kind = 3'd1;
      else if (B.zero)                               begin x.kind = 3'd3; x.dbz = !A.inf; end
      else if (A.inf)                                x.kind = 3'd3;
      else if (A.zero || B.inf)                      x.kind = 3'd4;
    end else begin
      if (A.nan)                 x.kind = 3'd2;
      else if (A.s && !A.zero)   x.kind = 3'd1;
      else if (A.zero)           x.kind = 3'd4;
      else if (A.inf)            x.kind = 3'd3;
    end
    x.sb = (x.kind == 3'd0);
    norm = x.sb && (A.sub || (dv && B.sub));
    x.num = (norm && A.sub) ? A.norm : A.raw;
    x.en  = 12'((norm && A.sub) ? 1 - A.shift : A.exp);
    x.den = (norm && B.sub) ? B.norm : B.raw;
    x.ed  = 12'((norm && B.sub) ? 1 - B.shift : B.exp);
    sh = A.shift;
    if (dv && B.shift > sh) sh = B.shift;
    x.lat = norm ? 1 + (sh + STEP - 1) / STEP : 1;
    return x;
  endfunction

  function automatic logic [63:0] gen_op(input logic [1:0] f);
    int ew, mw, cls;
    logic [63:0] e, m, emax, s;
    widths(f, ew, mw);
    emax = (64'd1 << ew) - 1;
    m    = {$urandom, $urandom} & ((64'd1 << mw) - 1);
    s    = 64'($urandom_range(0, 1));
    cls  = $urandom_range(0, 6);
    case (cls)
      0: begin e = 0; m = 0; end
      1, 2: begin e = 0; m = m >> $urandom_range(0, mw - 1); if (m == 0) m = 1; end
      3, 4: e = 64'($urandom_range(1, 32'(emax) - 1));
      5: begin e = emax; m = 0; end
      default: begin e = emax; if (m == 0) m = 1; end
    endcase
    return (s << (ew + mw)) | (e << mw) | m;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!Ready_SO && n < 200) begin step(); n++; end
    if (!Ready_SO) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic run_op(input logic dv, input logic [1:0] f, input logic [63:0] a, input logic [63:0] b, input int hold);
    exp_t x;
    int n;
    wait_ready();
    x = ref_model(dv, f, a, b);
    x.req_cyc = cyc;
    sbq.push_back(x);
    Div_start_SI  = dv;
    Sqrt_start_SI = dv ? 1'($urandom_range(0, 1)) : 1'b1;
    Format_sel_SI = f;
    Operand_a_DI  = a;
    Operand_b_DI  = b;
    Ready_SI      = (hold == 0);
    step();
    Div_start_SI  = 1'b0;
    Sqrt_start_SI = 1'b0;
    Format_sel_SI = 2'($urandom_range(0, 3));
    Operand_a_DI  = {$urandom, $urandom};
    Operand_b_DI  = {$urandom, $urandom};
    if (hold > 0) begin
      n = 0;
      while (!Start_SO && n < 20) begin step(); n++; end
      if (!Start_SO) check("start_timeout", 0, 1);
      repeat (hold) step();
      Ready_SI = 1'b1;
      step();
      check("ready_after_ack", Ready_SO, 1);
    end
  endtask

  // Monitor: checks every cycle Start_SO is high; pops on acceptance.
  logic prev_sb = 1'b1, prev_start = 1'b0;
  always @(negedge Clk_CI) begin
    if (!Rst_RBI) begin
      prev_sb    = 1'b1;
      prev_start = 1'b0;
    end else begin
      check("sbo_dly", Special_case_dly_SBO, prev_sb);
      prev_sb = Special_case_SBO;
      if (Start_SO) begin
        if (sbq.size() == 0) check("unexpected_start", Start_SO, 0);
        else begin
          if (!prev_start) check("latency", 64'(cyc - sbq[0].req_cyc), 64'(sbq[0].lat));
          check("div_op", Div_op_SO, sbq[0].dv);
          check("fmt", Format_sel_SO, sbq[0].fmt);
          check("num", Numerator_DO, sbq[0].num);
          check("exp_num", Exp_num_DO, sbq[0].en);
          if (sbq[0].dv) begin
            check("den", Denominator_DO, sbq[0].den);
            check("exp_den", Exp_den_DO, sbq[0].ed);
          end
          check("sign", Sign_z_SO, sbq[0].sign);
          check("special_b", Special_case_SBO, sbq[0].sb);
          check("kind", Special_kind_DO, sbq[0].kind);
          check("div_by_zero", Div_by_zero_SO, sbq[0].dbz);
          if (Ready_SI) void'(sbq.pop_front());
        end
      end
      prev_start = Start_SO;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dv;
    logic [1:0] f;
    repeat (3) step();
    check("rst_ready", Ready_SO, 1);
    check("rst_start", Start_SO, 0);
    check("rst_sbo", Special_case_SBO, 1);
    check("rst_sbo_dly", Special_case_dly_SBO, 1);
    check("rst_num", Numerator_DO, 0);
    check("rst_exp_num", Exp_num_DO, 0);
    check("rst_den", Denominator_DO, 0);
    check("rst_kind", Special_kind_DO, 0);
    check("rst_dbz", Div_by_zero_SO, 0);
    check("rst_div_op", Div_op_SO, 0);
    Rst_RBI = 1'b1;
    step();

    run_op(1'b1, 2'b00, 64'h40C00000, 64'h40000000, 0);
    run_op(1'b0, 2'b01, 64'h0000000000000001, 64'h0, 0);
    run_op(1'b1, 2'b00, 64'h3F800000, 64'h00000000, 0);
    run_op(1'b0, 2'b10, 64'hC400, 64'h0, 0);
    run_op(1'b1, 2'b10, 64'h7E00, 64'h3C00, 0);

    // Kill in the third NORM cycle of a long FP64 normalisation.
    wait_ready();
    Div_start_SI = 1'b1; Format_sel_SI = 2'b01;
    Operand_a_DI = 64'h3FF0000000000000; Operand_b_DI = 64'h1; Ready_SI = 1'b1;
    step();
    Div_start_SI = 1'b0;
    step(); step();
    check("kill_busy", Ready_SO, 0);
    Kill_SI = 1'b1;
    step();
    Kill_SI = 1'b0;
    check("kill_ready", Ready_SO, 1);
    check("kill_start", Start_SO, 0);
    check("kill_sbo", Special_case_SBO, 1);
    run_op(1'b1, 2'b00, 64'h40C00000, 64'h40000000, 0);

    run_op(1'b1, 2'b00, 64'h40C00000, 64'h40000000, 3);

    // Asynchronous reset in the middle of normalisation.
    wait_ready();
    Sqrt_start_SI = 1'b1; Format_sel_SI = 2'b01; Operand_a_DI = 64'h1;
    step();
    Sqrt_start_SI = 1'b0;
    step();
    check("arst_busy", Ready_SO, 0);
    Rst_RBI = 1'b0;
    #1;
    check("arst_ready", Ready_SO, 1);
    check("arst_num", Numerator_DO, 0);
    check("arst_exp_num", Exp_num_DO, 0);
    #2;
    Rst_RBI = 1'b1;
    step();

    for (int i = 0; i < 300; i++) begin
      dv = 1'($urandom_range(0, 1));
      f  = 2'($urandom_range(0, 3));
      run_op(dv, f, gen_op(f), gen_op(f), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    wait_ready();
    repeat (3) step();
    check("scoreboard_drained", 64'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
